// File: rtl/edge_pulse_multi.sv
// -----------------------------------------------------------------------------
// edge_pulse_multi
//
// Multi-channel key front end for the Morse timing/decoder logic. Each channel
// synchronises a raw asynchronous key level, debounces it, and emits a
// one-clock pulse on the edge selected by `mode`. Every pulse also sets a
// sticky pending flag which the consumer clears with `clr_pending`.
//
// Parameters:
//   CHANNELS        number of independent channels (>= 1)
//   SYNC_STAGES     synchroniser depth per channel (>= 2)
//   DEBOUNCE_CYCLES cycles a new level must persist before it is accepted (>= 1)
//
// Ports:
//   clk          system clock, all state updates on the rising edge
//   clrn         asynchronous active-low reset, release synchronous to clk
//   raw_in       raw key levels, bit i = channel i (asynchronous)
//   mode         edge select for all channels:
//                00 rise, 01 fall, 10 both, 11 pulses disabled
//   clr_pending  bit i clears pending[i] (a pulse in the same cycle wins)
//   level        debounced level per channel
//   pulse        one-cycle edge pulse per channel
//   pulse_any    OR of all pulse bits, coincident with pulse
//   pending      sticky per-channel flag, set by pulse
//
// All outputs come straight from flops; there is no combinational path from
// any input to any output.
// -----------------------------------------------------------------------------
module edge_pulse_multi #(
  parameter int CHANNELS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                clk,
  input  logic                clrn,
  input  logic [CHANNELS-1:0] raw_in,
  input  logic [1:0]          mode,
  input  logic [CHANNELS-1:0] clr_pending,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] pulse,
  output logic                pulse_any,
  output logic [CHANNELS-1:0] pending
);

  // Counter only needs to hold 0 .. DEBOUNCE_CYCLES-1; the value that would
  // reach DEBOUNCE_CYCLES is never stored because acceptance clears it.
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  // Count value whose increment reaches DEBOUNCE_CYCLES -> accept this edge.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] MODE_RISE = 2'b00;
  localparam logic [1:0] MODE_FALL = 2'b01;
  localparam logic [1:0] MODE_BOTH = 2'b10;
  localparam logic [1:0] MODE_OFF  = 2'b11;

  localparam logic [CHANNELS-1:0] CH_ZERO = {CHANNELS{1'b0}};

  // Synchroniser chain, stage 0 samples raw_in; last stage feeds the debouncer.
  logic [CHANNELS-1:0] sync_r [SYNC_STAGES];
  logic [CHANNELS-1:0] sync_s;

  // Debounce state and next-state.
  logic [CNT_W-1:0]    cnt_r     [CHANNELS];
  logic [CNT_W-1:0]    cnt_nxt_s [CHANNELS];
  logic [CHANNELS-1:0] accept_s;

  // Output registers and their next-state values.
  logic [CHANNELS-1:0] level_r;
  logic [CHANNELS-1:0] level_nxt_s;
  logic [CHANNELS-1:0] pulse_r;
  logic [CHANNELS-1:0] pulse_nxt_s;
  logic                pulse_any_r;
  logic [CHANNELS-1:0] pending_r;
  logic [CHANNELS-1:0] pending_nxt_s;

  assign sync_s = sync_r[SYNC_STAGES-1];

  // Synchroniser flops: shift raw levels through SYNC_STAGES registers.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int j = 0; j < SYNC_STAGES; j++) begin
        sync_r[j] <= CH_ZERO;
      end
    end else begin
      sync_r[0] <= raw_in;
      for (int j = 1; j < SYNC_STAGES; j++) begin
        sync_r[j] <= sync_r[j-1];
      end
    end
  end

  // Debounce next-state: count consecutive cycles the synchronised level
  // disagrees with the accepted level; any agreement restarts the count.
  always_comb begin
    accept_s = CH_ZERO;
    for (int c = 0; c < CHANNELS; c++) begin
      cnt_nxt_s[c] = CNT_ZERO;
      if (sync_s[c] == level_r[c]) begin
        cnt_nxt_s[c] = CNT_ZERO;
        accept_s[c]  = 1'b0;
      end else if (cnt_r[c] == CNT_LAST) begin
        cnt_nxt_s[c] = CNT_ZERO;
        accept_s[c]  = 1'b1;
      end else begin
        cnt_nxt_s[c] = cnt_r[c] + CNT_ONE;
        accept_s[c]  = 1'b0;
      end
    end
  end

  // An accepted change always flips the level, so XOR is sufficient.
  assign level_nxt_s = level_r ^ accept_s;

  // Edge qualification: mode is sampled on the acceptance edge itself, so a
  // mode change mid-debounce only affects the eventual pulse decision.
  always_comb begin
    pulse_nxt_s = CH_ZERO;
    case (mode)
      MODE_RISE: pulse_nxt_s = accept_s & level_nxt_s;
      MODE_FALL: pulse_nxt_s = accept_s & ~level_nxt_s;
      MODE_BOTH: pulse_nxt_s = accept_s;
      MODE_OFF:  pulse_nxt_s = CH_ZERO;
      default:   pulse_nxt_s = CH_ZERO;
    endcase
  end

  // Pending next-state: a new pulse sets the flag and beats a same-cycle clear.
  always_comb begin
    pending_nxt_s = pulse_nxt_s | (pending_r & ~clr_pending);
  end

  // Debounce counters per channel.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int c = 0; c < CHANNELS; c++) begin
        cnt_r[c] <= CNT_ZERO;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        cnt_r[c] <= cnt_nxt_s[c];
      end
    end
  end

  // Registered outputs: level, pulse, pulse_any and pending update together.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      level_r     <= CH_ZERO;
      pulse_r     <= CH_ZERO;
      pulse_any_r <= 1'b0;
      pending_r   <= CH_ZERO;
    end else begin
      level_r     <= level_nxt_s;
      pulse_r     <= pulse_nxt_s;
      pulse_any_r <= |pulse_nxt_s;
      pending_r   <= pending_nxt_s;
    end
  end

  assign level     = level_r;
  assign pulse     = pulse_r;
  assign pulse_any = pulse_any_r;
  assign pending   = pending_r;

endmodule

// File: doc/edge_pulse_multi.md
Name: edge_pulse_multi

Overview:
- Parametrised multi-channel successor to the single-key change detector used by the Morse front end.
- Per channel: synchronises a raw key/button level, debounces it, and emits a one-clock pulse on a selectable edge.
- Each pulse also sets a sticky pending flag that the consumer (decoder FSM) clears by handshake.
- Sits between the board keys and the Morse timing/decoder logic.

Parameters:
CHANNELS, 4, number of independent input channels (>=1)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
DEBOUNCE_CYCLES, 16, consecutive cycles a new level must persist before acceptance (>=1)

Ports:
clk  input  1  single system clock, all state updates on rising edge
clrn  input  1  asynchronous active-low reset
raw_in  input  CHANNELS  asynchronous raw key levels, bit i = channel i
mode  input  2  edge select for all channels: 00 rise, 01 fall, 10 both, 11 pulses disabled
clr_pending  input  CHANNELS  bit i high for one or more cycles clears pending[i]
level  output  CHANNELS  debounced level per channel
pulse  output  CHANNELS  one-cycle edge pulse per channel
pulse_any  output  1  OR of all pulse bits, same cycle
pending  output  CHANNELS  sticky flag, set by pulse, cleared by clr_pending

Behaviour:
- Reset (clrn low, asynchronous): all synchroniser flops, counters, level, pulse, pulse_any and pending go to 0 immediately and stay 0 while clrn is low. Release is synchronous to the next clk edge.
- Synchroniser: raw_in[i] passes through SYNC_STAGES flops. s[i] is the last stage.
- Debounce counter:
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
  - If s[i] == level[i], the counter clears to 0.
  - Otherwise the counter increments.
  - On the edge where the incremented value would reach DEBOUNCE_CYCLES, level[i] <= s[i] and the counter clears.
  - Any return of s[i] to level[i] before acceptance clears the counter, so glitches shorter than DEBOUNCE_CYCLES never propagate.
- Latency: if raw_in[i] changes before edge k and is then held, level[i] changes at edge k+SYNC_STAGES+DEBOUNCE_CYCLES-1. With defaults this is k+17.
- Pulse generation:
  - pulse[i] is registered and asserts at the same edge that level[i] updates. It is high for exactly one cycle.
  - Qualification uses mode sampled at that edge:
    - rise requires new level 1.
    - fall requires new level 0.
    - both accepts either edge.
    - 11 never pulses.
  - level tracks the input in every mode.
- pulse_any: registered OR of the next-state pulse bits, coincident with pulse.
- Pending handshake:
  - pending[i] sets on the edge pulse[i] asserts.
  - pending[i] clears on any edge with clr_pending[i]=1 and no pulse being set for that channel.
  - Simultaneous set and clear: set wins, pending[i] stays 1.
  - clr_pending on an already-clear channel has no effect.
- Channels are fully independent. Simultaneous events on multiple channels all pulse in the same cycle.
- Reset mid-debounce discards the partial count; level restarts from 0.
- An input held high through reset is accepted as a rising edge after the full latency following release.
- Mode change mid-debounce does not disturb counters. Only the qualification at the acceptance edge uses the new mode.
- No combinational path from any input to any output.

Test Plan:
- Reset, then raw_in[0] 0->1 held, mode=00, defaults -> level[0] and pulse[0] rise exactly 17 edges after the first sampling edge; pulse[0] is high 1 cycle; pending[0]=1; pulse_any=1 the same cycle.
- Glitch rejection: raw_in[1] high for 15 cycles then low, defaults -> level[1], pulse[1] and pending[1] stay 0. Repeat with 16 cycles -> level[1] goes 1.
- Mode sweep on channel 2 with a press/release each: mode=01 -> pulse only on release; mode=10 -> two pulses; mode=11 -> no pulses while level still toggles.
- Handshake: pending[3]=1; assert clr_pending[3] in the same cycle as a new pulse[3] -> pending[3] stays 1. Assert it on the next cycle alone -> pending[3]=0 at the following edge.
- All four channels rise in the same cycle -> pulse=4'b1111 for exactly one cycle and pulse_any=1 for one cycle.
- clrn pulled low asynchronously mid-count with raw_in=4'b0001 held -> all outputs 0 immediately. After release, level[0] rises 17 edges later with a pulse (mode=00).
